// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants and helpers for the FIFO write arbiter.
// No logic: states, the id-width helper and the FSM state type.
package fifo_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT
  } state_t;

  // Id width for n producers; a single-bit id is kept even for n <= 2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-write bundle between the producers, the arbiter and fifo_syn.
// master drives requests and the full flag; slave is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  import fifo_pkg::*;

  localparam int IDW = clog2(N);

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] data_in;
  logic [N-1:0]       ack;
  logic               fifo_full;
  logic               fifo_wr;
  logic [WIDTH-1:0]   fifo_data;
  logic [IDW-1:0]     owner;
  logic               busy;

  modport master (
    output req, data_in, fifo_full,
    input  ack, fifo_wr, fifo_data, owner, busy
  );

  modport slave (
    input  req, data_in, fifo_full,
    output ack, fifo_wr, fifo_data, owner, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin selector: first requester after 'last', wrapping modulo N.
// Purely combinational, no backpressure.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic           found,
  output logic [IDW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Offset 1 is checked first so the previous holder has lowest priority.
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (int'(last) + k) % N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo_syn write port among N producers.
// Latency: 1 IDLE cycle per grant, then combinational ack/wr; stalls while fifo_full.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_wr_arbiter_if.slave bus
);

  localparam int         IDW       = clog2(N);
  localparam logic [3:0] BURST_END = 4'(MAX_BURST);

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] last_q, last_d;
  logic [3:0]     burst_q, burst_d;
  logic [IDW-1:0] pick_idx;
  logic           pick_found;
  logic           own_req;
  logic           accept;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req   (bus.req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign own_req = bus.req[owner_q];
  assign accept  = (state_q == S_GRANT) && own_req && !bus.fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= IDW'(N - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          burst_d = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!own_req) begin
          last_d  = owner_q;
          state_d = S_IDLE;
        end else if (accept) begin
          burst_d = burst_q + 4'd1;
          if (burst_q + 4'd1 == BURST_END) begin
            last_d  = owner_q;
            state_d = S_IDLE;
          end
        end
        // Full with the owner still requesting: grant and count both hold.
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ack       = accept ? (N'(1) << owner_q) : '0;
  assign bus.fifo_wr   = accept;
  assign bus.fifo_data = accept ? bus.data_in[int'(owner_q)*WIDTH +: WIDTH] : '0;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q == S_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producers hold words until acked, FIFO writes are logged.
module tb_fifo_wr_arbiter;
  import fifo_pkg::*;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.WIDTH(W), .N(N)) bus ();

  fifo_wr_arbiter #(.WIDTH(W), .N(N), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [N-1:0] en;
  int           left [N];
  logic [7:0]   nxt  [N];
  logic         full_tb;

  logic [N-1:0] o_ack;
  logic         o_wr, o_busy;
  logic [7:0]   o_data;
  logic [1:0]   o_owner;
  logic [7:0]   wq[$];
  logic         whist[$];

  // One clock cycle: drive producers from pending words, sample at posedge+2, retire acked words.
  task automatic step(input bit rst_pulse);
    logic [N-1:0]   r;
    logic [N*W-1:0] d;
    r = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      r[i]         = en[i] && (left[i] > 0);
      d[i*W +: W]  = nxt[i];
    end
    bus.req       = r;
    bus.data_in   = d;
    bus.fifo_full = full_tb;
    if (rst_pulse) rst_n = 1'b0;
    #1;
    o_ack   = bus.ack;
    o_wr    = bus.fifo_wr;
    o_data  = bus.fifo_data;
    o_busy  = bus.busy;
    o_owner = bus.owner;
    whist.push_back(o_wr);
    if (o_wr) wq.push_back(o_data);
    for (int i = 0; i < N; i++) begin
      if (o_ack[i]) begin
        left[i]--;
        nxt[i]++;
      end
    end
    @(posedge clk);
    #1;
    if (rst_pulse) rst_n = 1'b1;
  endtask

  task automatic prod(input int i, input int words);
    en[i]   = 1'b1;
    left[i] = words;
    nxt[i]  = 8'(i * 16);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    en      = '0;
    full_tb = 1'b0;
    for (int i = 0; i < N; i++) begin
      left[i] = 0;
      nxt[i]  = 8'h00;
    end
    wq.delete();
    whist.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) prod(i, 8);
    step(1'b0);
    n_chk++; if (o_ack !== 4'b0000) $display("FAIL reset_ack got %b want 0000", o_ack); else n_pass++;
    n_chk++; if (o_wr !== 1'b0) $display("FAIL reset_wr got %b want 0", o_wr); else n_pass++;
    n_chk++; if (o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", o_busy); else n_pass++;
    n_chk++; if (o_owner !== 2'd0) $display("FAIL reset_owner got %0d want 0", o_owner); else n_pass++;
    n_chk++; if (o_data !== 8'h00) $display("FAIL reset_data got %h want 00", o_data); else n_pass++;
    rst_n = 1'b1;
    step(1'b0);
    n_chk++; if (o_busy !== 1'b0 || o_wr !== 1'b0) $display("FAIL reset_idle busy=%b wr=%b want 0 0", o_busy, o_wr); else n_pass++;
    step(1'b0);
    n_chk++; if (o_busy !== 1'b1 || o_owner !== 2'd0) $display("FAIL reset_first_grant busy=%b owner=%0d want 1 0", o_busy, o_owner); else n_pass++;
    n_chk++; if (o_ack !== 4'b0001 || o_data !== 8'h00) $display("FAIL reset_first_word ack=%b data=%h want 0001 00", o_ack, o_data); else n_pass++;
  endtask

  task automatic test_single_burst();
    logic [8:0] pat;
    do_reset();
    prod(2, 6);
    repeat (9) step(1'b0);
    pat = '0;
    for (int k = 0; k < 9; k++) pat[8-k] = whist[k];
    n_chk++; if (pat !== 9'b011110110) $display("FAIL single_wr_pattern got %b want 011110110", pat); else n_pass++;
    n_chk++; if (wq.size() != 6) $display("FAIL single_count got %0d want 6", wq.size()); else n_pass++;
    for (int k = 0; k < 6 && k < wq.size(); k++) begin
      n_chk++; if (wq[k] !== 8'(8'h20 + k)) $display("FAIL single_data[%0d] got %h want %h", k, wq[k], 8'(8'h20 + k)); else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) prod(i, 8);
    repeat (44) step(1'b0);
    n_chk++; if (wq.size() != 32) $display("FAIL rr_count got %0d want 32", wq.size()); else n_pass++;
    for (int k = 0; k < 32 && k < wq.size(); k++) begin
      int g;
      logic [7:0] exp_d;
      g     = k / 4;
      exp_d = 8'((g % 4) * 16 + (g / 4) * 4 + (k % 4));
      n_chk++; if (wq[k] !== exp_d) $display("FAIL rr_data[%0d] got %h want %h", k, wq[k], exp_d); else n_pass++;
    end
  endtask

  task automatic test_full_stall();
    logic [13:0] pat;
    do_reset();
    prod(1, 6);
    for (int c = 0; c < 14; c++) begin
      full_tb = (c >= 3 && c <= 7);
      step(1'b0);
      if (c >= 3 && c <= 7) begin
        n_chk++; if (o_wr !== 1'b0 || o_ack !== 4'b0000) $display("FAIL stall_c%0d wr=%b ack=%b want 0 0000", c, o_wr, o_ack); else n_pass++;
        n_chk++; if (o_busy !== 1'b1 || o_owner !== 2'd1) $display("FAIL stall_hold_c%0d busy=%b owner=%0d want 1 1", c, o_busy, o_owner); else n_pass++;
      end
    end
    full_tb = 1'b0;
    pat = '0;
    for (int k = 0; k < 14; k++) pat[13-k] = whist[k];
    n_chk++; if (pat !== 14'b01100000110110) $display("FAIL stall_wr_pattern got %b want 01100000110110", pat); else n_pass++;
    n_chk++; if (wq.size() != 6) $display("FAIL stall_count got %0d want 6", wq.size()); else n_pass++;
    for (int k = 0; k < 6 && k < wq.size(); k++) begin
      n_chk++; if (wq[k] !== 8'(8'h10 + k)) $display("FAIL stall_data[%0d] got %h want %h", k, wq[k], 8'(8'h10 + k)); else n_pass++;
    end
  endtask

  task automatic test_drop_wrap();
    do_reset();
    prod(1, 1);
    prod(3, 2);
    repeat (4) step(1'b0);
    prod(0, 1);
    prod(2, 1);
    step(1'b0);
    step(1'b0);
    n_chk++; if (wq.size() != 3 || wq[2] !== 8'h31) $display("FAIL drop_owner3_words size=%0d want 3 ending 31", wq.size()); else n_pass++;
    step(1'b0);
    n_chk++; if (o_wr !== 1'b0 || o_ack !== 4'b0000) $display("FAIL drop_release wr=%b ack=%b want 0 0000", o_wr, o_ack); else n_pass++;
    n_chk++; if (o_busy !== 1'b1 || o_owner !== 2'd3) $display("FAIL drop_release_owner busy=%b owner=%0d want 1 3", o_busy, o_owner); else n_pass++;
    step(1'b0);
    n_chk++; if (o_busy !== 1'b0 || o_wr !== 1'b0) $display("FAIL drop_bubble busy=%b wr=%b want 0 0", o_busy, o_wr); else n_pass++;
    step(1'b0);
    n_chk++; if (o_owner !== 2'd0 || o_busy !== 1'b1) $display("FAIL drop_wrap_owner got %0d busy=%b want 0 1", o_owner, o_busy); else n_pass++;
    n_chk++; if (o_wr !== 1'b1 || o_data !== 8'h00) $display("FAIL drop_wrap_word wr=%b data=%h want 1 00", o_wr, o_data); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    prod(2, 6);
    repeat (3) step(1'b0);
    step(1'b1);
    n_chk++; if (o_wr !== 1'b0 || o_ack !== 4'b0000) $display("FAIL midrst_wr wr=%b ack=%b want 0 0000", o_wr, o_ack); else n_pass++;
    n_chk++; if (o_busy !== 1'b0 || o_owner !== 2'd0) $display("FAIL midrst_state busy=%b owner=%0d want 0 0", o_busy, o_owner); else n_pass++;
    n_chk++; if (left[2] != 4) $display("FAIL midrst_pending got %0d want 4", left[2]); else n_pass++;
    prod(0, 1);
    step(1'b0);
    step(1'b0);
    n_chk++; if (o_owner !== 2'd0 || o_data !== 8'h00) $display("FAIL midrst_restart owner=%0d data=%h want 0 00", o_owner, o_data); else n_pass++;
    repeat (3) step(1'b0);
    n_chk++; if (o_owner !== 2'd2 || o_data !== 8'h22) $display("FAIL midrst_resume owner=%0d data=%h want 2 22", o_owner, o_data); else n_pass++;
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = '0;
    full_tb = 1'b0;
    bus.req       = '0;
    bus.data_in   = '0;
    bus.fifo_full = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_drop_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
